// File: rtl/elastic_pipe.sv
// DEPTH-stage valid/ready register pipeline with bubble collapse, flush and an optional skid entry (ELASTIC_PIPE_SKID_EN).
// Latency DEPTH cycles unstalled; stalled stages hold, empty stages keep filling, in_ready drops only when no slot can open.
module elastic_pipe #(
    parameter int              WIDTH = 8,
    parameter int              DEPTH = 2,
    parameter logic [WIDTH-1:0] INIT = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH-1:0]              out_data,
    output logic [$clog2(DEPTH+2)-1:0]    occupancy
);
    localparam int OW = $clog2(DEPTH+2);

    logic [DEPTH-1:0] v_q, v_d;
    logic [WIDTH-1:0] d_q [DEPTH];
    logic [DEPTH-1:0] rdy;
    logic [DEPTH-1:0] v_in;
    logic [WIDTH-1:0] d_in [DEPTH];
    logic             src_vld;
    logic [WIDTH-1:0] src_dat;
    logic [OW-1:0]    occ_q, occ_d;

    // A stage can load when it, or any stage downstream of it, is empty, or the sink takes a beat.
    for (genvar g = 0; g < DEPTH; g++) begin : g_rdy
        assign rdy[g] = out_ready | ~(&v_q[DEPTH-1:g]);
    end

    assign v_in[0] = src_vld;
    assign d_in[0] = src_dat;
    for (genvar g = 1; g < DEPTH; g++) begin : g_chain
        assign v_in[g] = v_q[g-1];
        assign d_in[g] = d_q[g-1];
    end

`ifdef ELASTIC_PIPE_SKID_EN
    logic             sv_q, sv_d;
    logic [WIDTH-1:0] sd_q;

    assign in_ready = !sv_q & !flush;
    assign src_vld  = sv_q | (in_valid & in_ready);
    assign src_dat  = sv_q ? sd_q : in_data;

    always_comb begin
        sv_d = sv_q;
        if (flush)
            sv_d = 1'b0;
        else if (sv_q && rdy[0])
            sv_d = 1'b0;
        else if (in_valid && in_ready && !rdy[0])
            sv_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sv_q <= 1'b0;
            sd_q <= INIT;
        end else begin
            sv_q <= sv_d;
            if (!sv_q && sv_d)
                sd_q <= in_data;
        end
    end
`else
    assign in_ready = rdy[0] & !flush;
    assign src_vld  = in_valid & in_ready;
    assign src_dat  = in_data;
`endif

    always_comb begin
        v_d = v_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (rdy[i])
                v_d[i] = v_in[i];
        end
        if (flush)
            v_d = '0;
    end

    always_comb begin
        occ_d = '0;
        for (int i = 0; i < DEPTH; i++)
            occ_d = occ_d + OW'(v_d[i]);
`ifdef ELASTIC_PIPE_SKID_EN
        occ_d = occ_d + OW'(sv_d);
`endif
    end

    // Data moves only with a valid beat, so an emptied output keeps showing the last beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q   <= '0;
            occ_q <= '0;
            for (int i = 0; i < DEPTH; i++)
                d_q[i] <= INIT;
        end else begin
            v_q   <= v_d;
            occ_q <= occ_d;
            for (int i = 0; i < DEPTH; i++) begin
                if (rdy[i] && v_in[i] && !flush)
                    d_q[i] <= d_in[i];
            end
        end
    end

    assign out_valid = v_q[DEPTH-1];
    assign out_data  = d_q[DEPTH-1];
    assign occupancy = occ_q;
endmodule

// File: tb/tb_elastic_pipe.sv
// Drives DEPTH=1,2,3 pipes with shared directed stimulus; a beat-position model checks every cycle.
module tb_elastic_pipe;
`ifdef ELASTIC_PIPE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, flush, in_valid, out_ready;
    logic [7:0] in_data;

    logic       ir1, ov1, ir2, ov2, ir3, ov3;
    logic [7:0] od1, od2, od3;
    logic [1:0] occ1, occ2;
    logic [2:0] occ3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    elastic_pipe #(.WIDTH(8), .DEPTH(1), .INIT(8'h00)) u1 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
        .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .occupancy(occ1));
    elastic_pipe #(.WIDTH(8), .DEPTH(2), .INIT(8'h00)) u2 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir2), .in_data(in_data),
        .out_valid(ov2), .out_ready(out_ready), .out_data(od2), .occupancy(occ2));
    elastic_pipe #(.WIDTH(8), .DEPTH(3), .INIT(8'h3C)) u3 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir3), .in_data(in_data),
        .out_valid(ov3), .out_ready(out_ready), .out_data(od3), .occupancy(occ3));

    logic [31:0] g_ir [3];
    logic [31:0] g_ov [3];
    logic [31:0] g_od [3];
    logic [31:0] g_occ [3];
    assign g_ir[0] = 32'(ir1);  assign g_ov[0] = 32'(ov1);  assign g_od[0] = 32'(od1);  assign g_occ[0] = 32'(occ1);
    assign g_ir[1] = 32'(ir2);  assign g_ov[1] = 32'(ov2);  assign g_od[1] = 32'(od2);  assign g_occ[1] = 32'(occ2);
    assign g_ir[2] = 32'(ir3);  assign g_ov[2] = 32'(ov3);  assign g_od[2] = 32'(od3);  assign g_occ[2] = 32'(occ3);

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Model: per pipe, beats in acceptance order with their stage index (-1 = skid entry).
    logic [7:0] md [3][8];
    int         mp [3][8];
    int         mc [3];
    logic [7:0] mlast [3];
    bit         mok = 1'b0;
    logic       s_rst, s_fl, s_iv, s_or;
    logic [7:0] s_id;
    bit         e_ir [3];
    bit         e_ov [3];

    function automatic logic [7:0] init_of(input int k);
        return (k == 2) ? 8'h3C : 8'h00;
    endfunction

    function automatic bit model_ir(input int k);
        bit busy;
        busy = 1'b0;
        if (mc[k] > 0)
            busy = (mp[k][mc[k]-1] == -1);
        if (s_fl)
            return 1'b0;
        if (SKID)
            return !busy;
        return (mc[k] < k + 1) || s_or;
    endfunction

    task automatic mstep(input int k, input bit ir, input bit ov);
        int d;
        int prev;
        d = k + 1;
        if (s_rst) begin
            mc[k]    = 0;
            mlast[k] = init_of(k);
            return;
        end
        if (ov && s_or) begin
            for (int i = 1; i < mc[k]; i++) begin
                md[k][i-1] = md[k][i];
                mp[k][i-1] = mp[k][i];
            end
            mc[k]--;
        end
        if (s_fl) begin
            mc[k] = 0;
            return;
        end
        prev = d;
        for (int i = 0; i < mc[k]; i++) begin
            if (mp[k][i] + 1 < prev) begin
                mp[k][i]++;
                if (mp[k][i] == d - 1)
                    mlast[k] = md[k][i];
            end
            prev = mp[k][i];
        end
        if (s_iv && ir) begin
            md[k][mc[k]] = s_id;
            mp[k][mc[k]] = (mc[k] == 0 || mp[k][mc[k]-1] > 0) ? 0 : -1;
            if (mp[k][mc[k]] == d - 1)
                mlast[k] = s_id;
            mc[k]++;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            s_rst = rst; s_fl = flush; s_iv = in_valid; s_id = in_data; s_or = out_ready;
            for (int k = 0; k < 3; k++) begin
                e_ir[k] = model_ir(k);
                e_ov[k] = (mc[k] > 0) && (mp[k][0] == k);
                if (mok) begin
                    chk($sformatf("u%0d in_ready", k + 1), g_ir[k], 32'(e_ir[k]));
                    chk($sformatf("u%0d out_valid", k + 1), g_ov[k], 32'(e_ov[k]));
                    chk($sformatf("u%0d out_data", k + 1), g_od[k], 32'(mlast[k]));
                    chk($sformatf("u%0d occupancy", k + 1), g_occ[k], 32'(mc[k]));
                end
            end
            @(posedge clk);
            for (int k = 0; k < 3; k++)
                mstep(k, e_ir[k], e_ov[k]);
            if (s_rst)
                mok = 1'b1;
        end
    end

    // Advance one cycle, drive the new inputs, then let combinational outputs settle.
    task automatic step(input logic r, input logic f, input logic v, input logic [7:0] d, input logic o);
        @(posedge clk);
        #1;
        rst = r; flush = f; in_valid = v; in_data = d; out_ready = o;
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        step(1, 0, 0, 8'h00, 0);
        step(0, 0, 0, 8'h00, 0);
        chk("reset u3 out_valid", 32'(ov3), 0);
        chk("reset u3 out_data", 32'(od3), 32'h3C);
        chk("reset u3 occupancy", 32'(occ3), 0);
        chk("reset u2 out_data", 32'(od2), 32'h00);

        // Stream 0x01..0x0A through DEPTH=3: beat accepted in cycle j exits in cycle j+3.
        for (int j = 0; j < 14; j++) begin
            step(0, 0, (j < 10), 8'(j + 1), 1);
            chk("stream u3 in_ready", 32'(ir3), 1);
            chk("stream u3 out_valid", 32'(ov3), 32'(j >= 3 && j <= 12));
            if (j >= 3 && j <= 12)
                chk("stream u3 out_data", 32'(od3), 32'(j - 2));
        end
        step(0, 0, 0, 8'h00, 1);

        // Backpressure on DEPTH=2.
        step(0, 0, 1, 8'hA1, 0);
        chk("bp u2 in_ready c0", 32'(ir2), 1);
        step(0, 0, 1, 8'hA2, 0);
        chk("bp u2 in_ready c1", 32'(ir2), 1);
        step(0, 0, 1, 8'hA3, 0);
        chk("bp u2 occupancy c2", 32'(occ2), 2);
`ifdef ELASTIC_PIPE_SKID_EN
        chk("bp u2 in_ready c2", 32'(ir2), 1);
`else
        chk("bp u2 in_ready c2", 32'(ir2), 0);
`endif
        step(0, 0, 1, 8'hA3, 1);
        chk("bp u2 out_data A1", 32'(od2), 32'hA1);
        chk("bp u2 out_valid c3", 32'(ov2), 1);
`ifdef ELASTIC_PIPE_SKID_EN
        chk("bp u2 in_ready skid full", 32'(ir2), 0);
        chk("bp u2 occupancy skid", 32'(occ2), 3);
`else
        chk("bp u2 in_ready released", 32'(ir2), 1);
`endif
        step(0, 0, 0, 8'h00, 1);
        chk("bp u2 out_data A2", 32'(od2), 32'hA2);
        step(0, 0, 0, 8'h00, 1);
        chk("bp u2 out_data A3", 32'(od2), 32'hA3);
        step(0, 0, 0, 8'h00, 1);
        chk("bp u2 empty out_valid", 32'(ov2), 0);
        chk("bp u2 empty out_data held", 32'(od2), 32'hA3);
        repeat (4) step(0, 0, 0, 8'h00, 1);

        // Bubble fill on DEPTH=3 behind a stalled 0x55.
        step(0, 0, 1, 8'h55, 0);
        step(0, 0, 0, 8'h00, 0);
        step(0, 0, 0, 8'h00, 0);
        step(0, 0, 1, 8'h66, 0);
        chk("bubble u3 head 55", 32'(od3), 32'h55);
        chk("bubble u3 occupancy 1", 32'(occ3), 1);
        chk("bubble u3 in_ready 66", 32'(ir3), 1);
        step(0, 0, 1, 8'h77, 0);
        chk("bubble u3 in_ready 77", 32'(ir3), 1);
        step(0, 0, 1, 8'h88, 0);
        chk("bubble u3 occupancy 3", 32'(occ3), 3);
`ifdef ELASTIC_PIPE_SKID_EN
        chk("bubble u3 in_ready full", 32'(ir3), 1);
`else
        chk("bubble u3 in_ready full", 32'(ir3), 0);
`endif
        step(0, 0, 0, 8'h00, 1);
        chk("bubble u3 out 55", 32'(od3), 32'h55);
        step(0, 0, 0, 8'h00, 1);
        chk("bubble u3 out 66", 32'(od3), 32'h66);
        step(0, 0, 0, 8'h00, 1);
        chk("bubble u3 out 77", 32'(od3), 32'h77);
        repeat (4) step(0, 0, 0, 8'h00, 1);

        // Flush with two beats in flight and the head transferring.
        step(0, 0, 1, 8'hB1, 0);
        step(0, 0, 1, 8'hB2, 0);
        step(0, 0, 0, 8'h00, 0);
        step(0, 1, 1, 8'hCC, 1);
        chk("flush u3 occupancy before", 32'(occ3), 2);
        chk("flush u3 head out_valid", 32'(ov3), 1);
        chk("flush u3 head out_data", 32'(od3), 32'hB1);
        chk("flush u3 in_ready", 32'(ir3), 0);
        chk("flush u1 in_ready", 32'(ir1), 0);
        step(0, 0, 0, 8'h00, 0);
        chk("flush u3 out_valid after", 32'(ov3), 0);
        chk("flush u3 occupancy after", 32'(occ3), 0);
        chk("flush u3 out_data kept", 32'(od3), 32'hB1);

        // Reset with two beats in flight.
        step(0, 0, 1, 8'hC1, 0);
        step(0, 0, 1, 8'hC2, 0);
        step(1, 0, 1, 8'hDD, 0);
        step(0, 0, 0, 8'h00, 0);
        chk("midrst u3 out_valid", 32'(ov3), 0);
        chk("midrst u3 out_data", 32'(od3), 32'h3C);
        chk("midrst u3 occupancy", 32'(occ3), 0);
        chk("midrst u2 out_data", 32'(od2), 32'h00);

        // Continuous input with toggling out_ready on DEPTH=1.
        for (int j = 0; j < 24; j++) begin
            step(0, 0, 1, 8'(8'h10 + j), (j % 2 == 0));
            chk("toggle u1 occupancy bound", 32'(occ1 <= 2'd2), 1);
        end
        repeat (5) step(0, 0, 0, 8'h00, 1);
        chk("toggle u1 drained out_valid", 32'(ov1), 0);
        chk("toggle u1 drained occupancy", 32'(occ1), 0);

        step(0, 0, 0, 8'h00, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/elastic_pipe.md
Name: elastic_pipe

Overview:
- Parametrised successor to the single enable flop: a DEPTH-stage, WIDTH-bit register pipeline with per-stage valid bits and valid/ready handshake on both sides.
- Stalled stages hold their data. Empty stages (bubbles) are filled even while downstream is stalled.
- Used on the arbitrated-FIFO datapaths to retime long routes without losing throughput or data under backpressure.

Parameters:
- WIDTH, 8, data width in bits (>=1).
- DEPTH, 2, number of register stages (>=1).
- INIT, 0, WIDTH-bit reset value of every stage data register.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  reset, synchronous, active-high.
- flush  input  1  discard all in-flight beats.
- in_valid  input  1  upstream beat present.
- in_ready  output  1  pipe accepts beat this cycle.
- in_data  input  WIDTH  upstream data.
- out_valid  output  1  last stage holds a beat.
- out_ready  input  1  downstream accepts beat.
- out_data  output  WIDTH  last stage data.
- occupancy  output  $clog2(DEPTH+2)  number of valid beats held, including the skid entry when enabled.

Behaviour:
- State per stage i (0..DEPTH-1):
  - v[i]: valid bit.
  - d[i]: WIDTH-bit data register.
- Reset: all v[i]=0 and all d[i]=INIT, the same cycle rst is sampled high.
- Reset overrides flush and any handshake in that cycle.
- Reset values of outputs: out_valid=0, out_data=INIT, occupancy=0.
- Ready chain, combinational:
  - rdy[DEPTH]=out_ready.
  - rdy[i] = !v[i] | rdy[i+1].
  - in_ready = rdy[0] & !flush.
- Stage load: when rdy[i]=1, the following update at the clock edge:
  - d[0] <= in_data.
  - v[0] <= in_valid & in_ready.
  - For i>0: d[i] <= d[i-1] and v[i] <= v[i-1].
- Stage hold: when rdy[i]=0, the stage keeps d[i] and v[i].
- Data registers load only when their stage loads; a stalled stage never changes d[i].
- Output: out_valid=v[DEPTH-1], out_data=d[DEPTH-1]. A transfer occurs when out_valid & out_ready.
- Latency: a beat accepted in cycle t appears on out_valid in cycle t+DEPTH when unstalled.
- Throughput: 1 beat/cycle sustained with out_ready=1.
- Bubble collapse: while out_ready=0, new beats keep entering until every stage is valid, then in_ready=0.
- Full: all v=1 and out_ready=0 gives in_ready=0.
  - With out_ready=1 while full, in_ready=1 in the same cycle (pass-through of ready).
- Empty: out_valid=0, and out_data holds its last value (INIT after reset).
- Flush:
  - All v[i] <= 0 next cycle.
  - in_ready=0 during flush, so no upstream handshake is lost.
  - An output transfer in the flush cycle (out_valid & out_ready) completes normally.
  - d[i] are unchanged by flush.
- occupancy: registered, equals the popcount of valid bits (plus skid entry) after each edge; 0 after reset or flush.
- Ordering: beats leave in acceptance order; no duplication, no loss except by flush or reset.

Optional Feature:
- Macro: ELASTIC_PIPE_SKID_EN.
- Defined:
  - A one-entry skid register (sv, sd) sits in front of stage 0.
  - in_ready = !sv & !flush, driven directly from a flop, which breaks the combinational ready chain to the upstream side.
  - Stage 0 source is sd when sv=1, otherwise in_data.
  - An accepted beat while rdy[0]=0 is captured into the skid: sv<=1, sd<=in_data.
  - sv clears when stage 0 loads from the skid.
  - Flush and reset clear sv.
  - Latency is unchanged when the skid is empty; occupancy max = DEPTH+1.
- Undefined: no skid; in_ready is combinational as specified above; occupancy max = DEPTH.

Test Plan:
- Stream: DEPTH=3, out_ready=1, push 0x01..0x0A on consecutive cycles → out 0x01..0x0A in order, first at cycle t+3, no gaps.
- Backpressure: DEPTH=2, out_ready=0, push 0xA1, 0xA2, 0xA3 → first two accepted; in_ready=0 on the third; occupancy=2; release out_ready → 0xA1, then 0xA2, then 0xA3 accepted.
- Bubble fill: DEPTH=3, one beat 0x55 at the last stage stalled → the next two beats still enter; occupancy=3.
- Flush: occupancy=2 with out_ready=1 during flush → the head beat is transferred; next cycle occupancy=0 and out_valid=0; in_ready=0 during the flush cycle.
- Reset mid-stream: rst high with 2 beats in flight → next cycle out_valid=0, out_data=INIT (test with INIT=0x3C), occupancy=0.
- With SKID_EN: DEPTH=1, out_ready toggling 1/0, continuous in_valid → no beat lost or duplicated; in_ready only drops after the skid fills; occupancy never exceeds 2.
